// File: rtl/equiv_rpt_if.sv
// First-mismatch report channel of the equivalence tracker: valid/ready handshake
// carrying the captured cycle, both operands, their XOR diff and its popcount.
interface equiv_rpt_if #(
  parameter int WIDTH = 91,
  parameter int CNT_W = 16
);
  localparam int NB_W = $clog2(WIDTH + 1);

  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_cyc;
  logic [WIDTH-1:0] rpt_y1;
  logic [WIDTH-1:0] rpt_y2;
  logic [WIDTH-1:0] rpt_diff;
  logic [NB_W-1:0]  rpt_nbits;

  modport master (
    output rpt_valid, rpt_cyc, rpt_y1, rpt_y2, rpt_diff, rpt_nbits,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid, rpt_cyc, rpt_y1, rpt_y2, rpt_diff, rpt_nbits,
    output rpt_ready
  );
endinterface

// File: rtl/equiv_mismatch_tracker.sv
// Compares two harness results each clock after a settle window, counts mismatches and
// reports the first one. Define EQUIV_TRACKER_ASSERT_EN to add a mismatch assertion in CHECK.
module equiv_mismatch_tracker #(
  parameter int WIDTH         = 91,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_CYCLES    = 1024,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] y_1,
  input  logic [WIDTH-1:0] y_2,
  output logic [1:0]       state,
  output logic             fail,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] cyc_cnt,
  equiv_rpt_if.master      rpt
);
  localparam int NB_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_CHECK  = 2'd1,
    ST_FAIL   = 2'd2,
    ST_PASS   = 2'd3
  } state_t;

  localparam state_t RST_STATE = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;

  state_t           state_q, state_d;
  logic             fail_q, fail_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [31:0]      settle_q, settle_d;
  logic [31:0]      chk_q, chk_d;
  logic             rv_q, rv_d;
  logic [CNT_W-1:0] rcyc_q, rcyc_d;
  logic [WIDTH-1:0] ry1_q, ry1_d;
  logic [WIDTH-1:0] ry2_q, ry2_d;
  logic [WIDTH-1:0] rdiff_q, rdiff_d;
  logic [NB_W-1:0]  rnb_q, rnb_d;

  logic [WIDTH-1:0] diff_w;
  logic [NB_W-1:0]  nbits_w;
  logic             mm_w;

  assign diff_w = y_1 ^ y_2;
  assign mm_w   = (y_1 != y_2);

  always_comb begin
    nbits_w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      nbits_w = nbits_w + NB_W'(diff_w[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    mm_cnt_d = mm_cnt_q;
    cyc_d    = cyc_q;
    settle_d = settle_q;
    chk_d    = chk_q;
    rv_d     = rv_q;
    rcyc_d   = rcyc_q;
    ry1_d    = ry1_q;
    ry2_d    = ry2_q;
    rdiff_d  = rdiff_q;
    rnb_d    = rnb_q;

    if (cyc_q != '1) begin
      cyc_d = cyc_q + 1'b1;
    end

    // Report is only ever live in FAIL, so a completed transfer can never re-arm it.
    if (rv_q && rpt.rpt_ready) begin
      rv_d = 1'b0;
    end

    unique case (state_q)
      ST_SETTLE: begin
        if (settle_q == 32'(SETTLE_CYCLES - 1)) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q + 32'd1;
        end
      end
      ST_CHECK: begin
        chk_d = chk_q + 32'd1;
        if (mm_w) begin
          state_d  = ST_FAIL;
          fail_d   = 1'b1;
          mm_cnt_d = (mm_cnt_q != '1) ? mm_cnt_q + 1'b1 : mm_cnt_q;
          rv_d     = 1'b1;
          rcyc_d   = cyc_q;
          ry1_d    = y_1;
          ry2_d    = y_2;
          rdiff_d  = diff_w;
          rnb_d    = nbits_w;
        end else if (MAX_CYCLES != 0 && chk_q == 32'(MAX_CYCLES - 1)) begin
          state_d = ST_PASS;
          pass_d  = 1'b1;
        end
      end
      ST_FAIL: begin
        if (mm_w && mm_cnt_q != '1) begin
          mm_cnt_d = mm_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_STATE;
      fail_q   <= 1'b0;
      pass_q   <= 1'b0;
      mm_cnt_q <= '0;
      cyc_q    <= '0;
      settle_q <= '0;
      chk_q    <= '0;
      rv_q     <= 1'b0;
      rcyc_q   <= '0;
      ry1_q    <= '0;
      ry2_q    <= '0;
      rdiff_q  <= '0;
      rnb_q    <= '0;
    end else begin
      state_q  <= state_d;
      fail_q   <= fail_d;
      pass_q   <= pass_d;
      mm_cnt_q <= mm_cnt_d;
      cyc_q    <= cyc_d;
      settle_q <= settle_d;
      chk_q    <= chk_d;
      rv_q     <= rv_d;
      rcyc_q   <= rcyc_d;
      ry1_q    <= ry1_d;
      ry2_q    <= ry2_d;
      rdiff_q  <= rdiff_d;
      rnb_q    <= rnb_d;
    end
  end

`ifdef EQUIV_TRACKER_ASSERT_EN
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(state_q == ST_CHECK && y_1 != y_2));
    end
  end
`endif

  assign state         = state_q;
  assign fail          = fail_q;
  assign pass          = pass_q;
  assign mismatch_cnt  = mm_cnt_q;
  assign cyc_cnt       = cyc_q;
  assign rpt.rpt_valid = rv_q;
  assign rpt.rpt_cyc   = rcyc_q;
  assign rpt.rpt_y1    = ry1_q;
  assign rpt.rpt_y2    = ry2_q;
  assign rpt.rpt_diff  = rdiff_q;
  assign rpt.rpt_nbits = rnb_q;
endmodule

// File: doc/equiv_mismatch_tracker.md
Name: equiv_mismatch_tracker

Overview:
- Downstream consumer of the equivalence harness outputs y_1/y_2 (the two 91-bit design-under-comparison results).
- Compares the two results every clock after a post-reset settle window.
- Counts mismatches and captures the first failing cycle's operands and XOR diff.
- Presents a one-shot failure report on a valid/ready handshake, plus terminal pass/fail status for the fuzz-run controller.

Parameters:
- WIDTH, 91, width of y_1/y_2.
- SETTLE_CYCLES, 4, compare edges ignored after reset release. 0 = check from first edge.
- MAX_CYCLES, 1024, checked edges before PASS is declared. 0 = unbounded.
- CNT_W, 16, width of the cycle and mismatch counters.

Ports:
- clk  input  1  rising-edge clock, shared with harness.
- rst  input  1  synchronous, active-high reset.
- y_1  input  WIDTH  result of first implementation.
- y_2  input  WIDTH  result of second implementation.
- rpt_ready  input  1  report consumer ready.
- state  output  2  0=SETTLE, 1=CHECK, 2=FAIL, 3=PASS.
- fail  output  1  sticky mismatch flag.
- pass  output  1  run completed with no mismatch.
- mismatch_cnt  output  CNT_W  saturating count of mismatching checked edges.
- cyc_cnt  output  CNT_W  saturating count of edges since reset release.
- rpt_valid  output  1  first-mismatch report valid.
- rpt_cyc  output  CNT_W  cyc_cnt value at first mismatch.
- rpt_y1  output  WIDTH  y_1 at first mismatch.
- rpt_y2  output  WIDTH  y_2 at first mismatch.
- rpt_diff  output  WIDTH  rpt_y1 ^ rpt_y2.
- rpt_nbits  output  clog2(WIDTH+1)  popcount of rpt_diff.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - rst is synchronous and active-high.
- Reset values:
  - state = SETTLE, or CHECK if SETTLE_CYCLES==0.
  - fail=0, pass=0, mismatch_cnt=0, cyc_cnt=0, rpt_valid=0.
  - rpt_cyc/rpt_y1/rpt_y2/rpt_diff/rpt_nbits = 0.
- Reset mid-run discards everything, including a pending report.
- cyc_cnt:
  - Increments on every non-reset edge.
  - Saturates at all-ones.
- Compare:
  - mm = (y_1 != y_2), sampled at the edge.
  - No input pipeline: a mismatch at edge N is visible on outputs after edge N.
- SETTLE:
  - mm ignored.
  - Leaves for CHECK on the edge where SETTLE_CYCLES edges have elapsed (settle counter == SETTLE_CYCLES-1).
  - A mismatch on that last settle edge is ignored.
- CHECK:
  - mm=1: go to FAIL; fail=1; mismatch_cnt+=1.
  - On the same edge, capture rpt_cyc=cyc_cnt (pre-increment), rpt_y1, rpt_y2, rpt_diff and rpt_nbits; set rpt_valid=1.
  - mm=0, MAX_CYCLES!=0, and checked-edge count reaches MAX_CYCLES: go to PASS; pass=1.
  - mm=1 on that same edge: FAIL wins and pass stays 0.
- FAIL:
  - Terminal until rst.
  - Keeps incrementing mismatch_cnt on every mm=1 edge, saturating at all-ones.
  - Capture registers frozen.
- PASS:
  - Terminal until rst.
  - mm ignored; mismatch_cnt stays 0.
- Report handshake:
  - rpt_valid rises once per run and holds, with payload stable, until an edge with rpt_valid&&rpt_ready; it then clears and never re-asserts before rst.
  - rpt_ready is don't-care while rpt_valid=0.
  - rpt_ready high at the capture edge does not complete the transfer; the earliest completion is the following edge.
- Width rules:
  - Counters are unsigned.
  - Saturation check precedes increment.
  - rpt_nbits is computed combinationally from y_1^y_2 and registered at capture.

Optional Feature:
- EQUIV_TRACKER_ASSERT_EN
  - Defined: adds a clocked immediate assertion `assert(!(state==CHECK && y_1!=y_2))` for formal/simulation flows, so the first mismatch also fails the proof/sim.
  - Undefined: no assertion logic; the block is pure synthesizable monitoring RTL.
  - Ports and cycle behaviour are identical either way.

Test Plan:
1. Settle window: rst 1 cycle; y_1=0, y_2=1 for 4 edges, then equal → state goes 0→1 after edge 4, fail=0, mismatch_cnt=0.
2. First mismatch capture: after settle, at cyc_cnt=10 drive y_1=91'h5, y_2=91'h6 → fail=1, state=2, rpt_valid=1, rpt_cyc=10, rpt_diff=91'h3, rpt_nbits=2, mismatch_cnt=1.
3. Handshake: hold rpt_ready=0 for 5 cycles, then 1 → payload stable throughout; rpt_valid clears one edge later; further mismatches leave rpt_valid=0 while mismatch_cnt keeps counting.
4. Pass path: MAX_CYCLES=8, equal inputs → pass=1, state=3 after the 8th checked edge; a later mismatch leaves fail=0.
5. Simultaneous: mismatch on the 8th checked edge with MAX_CYCLES=8 → state=FAIL, pass=0.
6. Reset mid-report: rst while rpt_valid=1 → all outputs return to reset values next edge; a new mismatch re-captures a fresh report.
